ddr_word_tx: RTL and testbench

Output-side counterpart of the IDDRC capture path: accepts parallel words over a valid/ready handshake and serializes them, two bits per `clk` cycle, onto the D0/D1/TX inputs of an ODDR output primitive. It sits between fabric logic and the pad. It frames each burst with one lead cycle and one trail cycle, during which the pad is driven to the idle level. Outside bursts the pad is tri-stated. Back-to-back words stream with no gap.

---
 rtl/ddr_tx_pkg.sv | 23 ++
 rtl/ddr_tx_pad.sv | 28 ++
 rtl/ddr_word_tx.sv | 143 ++++++++++++++
 tb/tb_ddr_word_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_tx_pkg.sv
// Shared state encoding and sizing helpers for the DDR word transmitter and its pad stage.
package ddr_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    SHIFT = 2'd2,
    POST  = 2'd3
  } tx_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int MIN_CNT_W = 1;

  // Two bits leave per clk cycle, so a word takes WIDTH/2 beats.
  function automatic int beats(input int width);
    return width / 2;
  endfunction

  function automatic int cnt_width(input int width);
    return ($clog2(width / 2) > MIN_CNT_W) ? $clog2(width / 2) : MIN_CNT_W;
  endfunction

endpackage

// File: rtl/ddr_tx_pad.sv
// Pad stage: presents D0/D1/TX to the ODDR output cell; Q0/Q1/T follow one clk later.
// Kept outside ddr_word_tx so the serializer simulates without vendor cells.
module ddr_tx_pad (
  input  logic clk,
  input  logic d0_i,
  input  logic d1_i,
  input  logic tx_i,
  output logic q0_o,
  output logic q1_o,
  output logic t_o
);

  logic q0_q;
  logic q1_q;
  logic t_q;

  // Same capture behaviour as the ODDR: both halves and the enable sampled on the rising edge.
  always_ff @(posedge clk) begin
    q0_q <= d0_i;
    q1_q <= d1_i;
    t_q  <= tx_i;
  end

  assign q0_o = q0_q;
  assign q1_o = q1_q;
  assign t_o  = t_q;

endmodule

// File: rtl/ddr_word_tx.sv
// Serializes valid/ready words two bits per clk onto ODDR D0/D1/TX, framed by one lead and one trail cycle.
// Accept at edge N: PRE in N+1, beats N+2..N+1+B, POST N+2+B; ready only in IDLE and on the last beat.
module ddr_word_tx
  import ddr_tx_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter logic IDLE_LVL  = 1'b0,
  parameter bit   LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             d0_o,
  output logic             d1_o,
  output logic             tx_o,
  output logic             frame_o,
  output logic             busy_o
);

  localparam int            B             = beats(WIDTH);
  localparam int            CW            = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BEAT     = CW'(B - 1);
  localparam logic          LAST_IS_FIRST = (B == 1);

  if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_width_chk
    $error("ddr_word_tx: WIDTH must be even and at least 2");
  end

  tx_state_e        state_q;
  logic [CW-1:0]    beat_q;
  logic [WIDTH-1:0] sreg_q;
  logic             ready_q;
  logic             d0_q;
  logic             d1_q;
  logic             tx_q;
  logic             frame_q;
  logic             busy_q;

  logic             accept;
  logic [WIDTH-1:0] src_w;
  logic [WIDTH-1:0] rest_w;
  logic             bit0_w;
  logic             bit1_w;
  logic [CW-1:0]    beat_inc;

  assign accept   = valid_i && ready_q;
  // A word accepted on the last beat is sent straight from the input, skipping the shift register.
  assign src_w    = accept ? data_i : sreg_q;
  assign beat_inc = beat_q + CW'(1);

  if (LSB_FIRST) begin : g_lsb
    assign bit0_w = src_w[0];
    assign bit1_w = src_w[1];
    assign rest_w = src_w >> 2;
  end else begin : g_msb
    assign bit0_w = src_w[WIDTH-1];
    assign bit1_w = src_w[WIDTH-2];
    assign rest_w = src_w << 2;
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      sreg_q  <= '0;
      ready_q <= 1'b0;
      d0_q    <= IDLE_LVL;
      d1_q    <= IDLE_LVL;
      tx_q    <= 1'b1;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Framing cycle unless a branch below says otherwise.
      ready_q <= 1'b0;
      d0_q    <= IDLE_LVL;
      d1_q    <= IDLE_LVL;
      tx_q    <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= PRE;
            sreg_q  <= data_i;
            beat_q  <= '0;
          end else begin
            ready_q <= 1'b1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        PRE: begin
          state_q <= SHIFT;
          beat_q  <= '0;
          sreg_q  <= rest_w;
          d0_q    <= bit0_w;
          d1_q    <= bit1_w;
          frame_q <= 1'b1;
          ready_q <= LAST_IS_FIRST;
        end
        SHIFT: begin
          if (beat_q != LAST_BEAT) begin
            beat_q  <= beat_inc;
            sreg_q  <= rest_w;
            d0_q    <= bit0_w;
            d1_q    <= bit1_w;
            ready_q <= (beat_inc == LAST_BEAT);
          end else if (accept) begin
            beat_q  <= '0;
            sreg_q  <= rest_w;
            d0_q    <= bit0_w;
            d1_q    <= bit1_w;
            frame_q <= 1'b1;
            ready_q <= LAST_IS_FIRST;
          end else begin
            state_q <= POST;
          end
        end
        POST: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign d0_o    = d0_q;
  assign d1_o    = d1_q;
  assign tx_o    = tx_q;
  assign frame_o = frame_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_ddr_word_tx.sv
// Scoreboard bench: two serializers (LSB-first/idle 0 and MSB-first/idle 1) share one stimulus stream.
`timescale 1ns/1ps
module tb_ddr_word_tx;

  localparam int W = 8;
  localparam int B = W / 2;

  typedef struct packed {
    int   cyc;
    logic rdy;
    logic d0;
    logic d1;
    logic tx;
    logic fr;
    logic bz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data;
  logic         valid;
  logic [1:0]   rdy, d0, d1, tx, fr, bz;
  logic         q0, q1, qt;

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  exp_t expq0[$];
  exp_t expq1[$];
  logic [W-1:0] wq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddr_word_tx #(.WIDTH(W), .IDLE_LVL(1'b0), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_i(rst_n), .data_i(data), .valid_i(valid), .ready_o(rdy[0]),
    .d0_o(d0[0]), .d1_o(d1[0]), .tx_o(tx[0]), .frame_o(fr[0]), .busy_o(bz[0]));

  ddr_word_tx #(.WIDTH(W), .IDLE_LVL(1'b1), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_i(rst_n), .data_i(data), .valid_i(valid), .ready_o(rdy[1]),
    .d0_o(d0[1]), .d1_o(d1[1]), .tx_o(tx[1]), .frame_o(fr[1]), .busy_o(bz[1]));

  ddr_tx_pad pad_a (
    .clk(clk), .d0_i(d0[0]), .d1_i(d1[0]), .tx_i(tx[0]), .q0_o(q0), .q1_o(q1), .t_o(qt));

  function automatic logic idle_of(input int i);
    return (i == 1);
  endfunction

  function automatic bit lsb_of(input int i);
    return (i == 0);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_out(input string name, input exp_t g, input exp_t e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got cyc=%0d rdy,d0,d1,tx,frame,busy=%b%b%b%b%b%b expected cyc=%0d %b%b%b%b%b%b",
               name, g.cyc, g.rdy, g.d0, g.d1, g.tx, g.fr, g.bz,
               e.cyc, e.rdy, e.d0, e.d1, e.tx, e.fr, e.bz);
    end
  endtask

  task automatic push(input int i, input exp_t e);
    if (i == 0) expq0.push_back(e);
    else        expq1.push_back(e);
  endtask

  // Lead or trail cycle: pad driven, idle level, not ready.
  task automatic push_marker(input int c);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e.cyc = c;  e.rdy = 1'b0; e.d0 = idle_of(i); e.d1 = idle_of(i);
      e.tx = 1'b0; e.fr = 1'b0; e.bz = 1'b1;
      push(i, e);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w, input int first);
    exp_t e;
    int   lo, hi;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < B; k++) begin
        lo = lsb_of(i) ? 2 * k     : W - 1 - 2 * k;
        hi = lsb_of(i) ? 2 * k + 1 : W - 2 - 2 * k;
        e.cyc = first + k; e.rdy = (k == B - 1); e.d0 = w[lo]; e.d1 = w[hi];
        e.tx = 1'b0; e.fr = (k == 0); e.bz = 1'b1;
        push(i, e);
      end
    end
  endtask

  task automatic check_reset(input string name);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_dut%0d", name, i), 64'({rdy[i], d0[i], d1[i], tx[i], fr[i], bz[i]}),
          64'({1'b0, idle_of(i), idle_of(i), 1'b1, 1'b0, 1'b0}));
  endtask

  task automatic wait_accept(output bit ok, output int acc, output int waited);
    ok = 1'b0; acc = 0; waited = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rdy[0]) begin
        @(posedge clk); #1;
        acc = cyc; ok = 1'b1;
        return;
      end
      waited++;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 30 && !done; t++) begin
      @(posedge clk); #1;
      if (bz == 2'b00) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: busy=%b after 30 cycles, required 00", bz);
    end
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
  endtask

  // Sends every word in wq with valid held high, so all but the first ride the last-beat handshake.
  task automatic run_burst();
    int acc, waited, first, prev_first, n;
    bit ok;
    logic [W-1:0] w;
    n = wq.size(); prev_first = 0; first = 0;
    for (int i = 0; i < n; i++) begin
      w = wq[i]; data = w; valid = 1'b1;
      wait_accept(ok, acc, waited);
      if (!ok) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: word %0d not accepted, required within 20 cycles", i);
        break;
      end
      if (i == 0) begin
        chk("first_accept_wait", 64'(waited), 64'd0);
        push_marker(acc);
        first = acc + 1;
      end else begin
        chk("b2b_accept_cycle", 64'(acc), 64'(prev_first + B));
        first = acc;
      end
      push_word(w, first);
      if (i == n - 1) push_marker(first + B);
      prev_first = first;
    end
    valid = 1'b0;
    wq.delete();
    wait_idle();
  endtask

  initial begin : monitor
    exp_t e, g, prev;
    bit   prev_vld, have;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_vld = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          g.cyc = cyc; g.rdy = rdy[i]; g.d0 = d0[i]; g.d1 = d1[i];
          g.tx = tx[i]; g.fr = fr[i]; g.bz = bz[i];
          have = 1'b1;
          if (bz[i] || !tx[i]) begin
            if (i == 0 && expq0.size() > 0)      e = expq0.pop_front();
            else if (i == 1 && expq1.size() > 0) e = expq1.pop_front();
            else have = 1'b0;
            if (have) chk_out($sformatf("dut%0d_out", i), g, e);
            else begin
              n_cmp++; n_bad++;
              $display("FAIL dut%0d_unexpected: got busy,tx=%b%b at cycle %0d, expected idle 01", i, bz[i], tx[i], cyc);
            end
          end else begin
            e.cyc = cyc; e.rdy = 1'b1; e.d0 = idle_of(i); e.d1 = idle_of(i);
            e.tx = 1'b1; e.fr = 1'b0; e.bz = 1'b0;
            chk_out($sformatf("dut%0d_idle", i), g, e);
          end
          if (i == 0) begin
            if (prev_vld) chk("pad_q0q1t", 64'({q0, q1, qt}), 64'({prev.d0, prev.d1, prev.tx}));
            prev = e; prev_vld = have;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 ns");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc, waited, n;
    bit ok;
    rst_n = 1'b0; valid = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk("ready_before_first_edge", 64'(rdy), 64'd0);
    @(posedge clk); #1;
    chk("ready_after_release", 64'(rdy), 64'h3);
    mon_en = 1'b1;

    wq.push_back(8'hA5); run_burst();
    wq.push_back(8'hA5); wq.push_back(8'h3C); run_burst();
    wq.push_back(8'h0F); run_burst();

    // Reset lands during beat 1 of a word; the rest of that word must vanish.
    data = 8'hA5; valid = 1'b1;
    wait_accept(ok, acc, waited);
    valid = 1'b0;
    chk("mid_reset_accept", 64'(ok), 64'd1);
    push_marker(acc);
    push_word(8'hA5, acc + 1);
    while (cyc < acc + 2) begin @(posedge clk); #1; end
    mon_en = 1'b0; rst_n = 1'b0; #1;
    check_reset("reset_mid_word");
    expq0.delete(); expq1.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_mid_reset", 64'(rdy), 64'h3);
    mon_en = 1'b1;
    wq.push_back(8'h81); run_burst();

    repeat (40) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) wq.push_back(W'($urandom));
      run_burst();
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("dut0_queue_drained", 64'(expq0.size()), 64'd0);
    chk("dut1_queue_drained", 64'(expq1.size()), 64'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
